// File: rtl/lmarv_cycle_sequencer.sv
// Instruction-cycle sequencer for the lmarv-1 core: FETCH/DECODE/EXEC/WB with memory
// handshakes and PC counter-chain controls. Optional memory timeout: SEQ_WAIT_TIMEOUT_EN.
module lmarv_cycle_sequencer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        cp,
  input  logic        n_mr,
  input  logic        run,
  input  logic        halt_req,
  input  logic        mem_ready,
  input  logic        need_mem,
  input  logic        branch_taken,
  output logic [3:0]  phase,
  output logic        mem_req,
  output logic        ir_load,
  output logic        rf_we,
  output logic        pc_n_pe,
  output logic        pc_cep,
  output logic        pc_cet,
  output logic [15:0] retired,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StWb, StHalt} state_e;

  state_e      state_q, state_d;
  logic        mem_flag_q, mem_flag_d;
  logic        br_flag_q, br_flag_d;
  logic [15:0] retired_q, retired_d;
  logic        fault_q, fault_d;
  logic        timeout;

`ifdef SEQ_WAIT_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Fires on the WAIT_MAX-th consecutive wait cycle; mem_ready on that cycle still wins.
  assign timeout = mem_req && !mem_ready && (wait_cnt_q == 8'(WAIT_MAX - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d == StFetch && state_q != StFetch) ||
        (state_q == StDecode && need_mem)) begin
      wait_cnt_d = '0;
    end else if (mem_req && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge cp or negedge n_mr) begin
    if (!n_mr) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  // WAIT_MAX only matters when the timeout is built.
  logic unused_wait_max;
  assign unused_wait_max = ^WAIT_MAX;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge cp or negedge n_mr) begin
    if (!n_mr) begin
      state_q    <= StIdle;
      mem_flag_q <= 1'b0;
      br_flag_q  <= 1'b0;
      retired_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_flag_q <= mem_flag_d;
      br_flag_q  <= br_flag_d;
      retired_q  <= retired_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_flag_d = mem_flag_q;
    br_flag_d  = br_flag_q;
    retired_d  = retired_q;
    fault_d    = fault_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end
      end
      StDecode: begin
        mem_flag_d = need_mem;
        state_d    = StExec;
      end
      StExec: begin
        if (!mem_flag_q || mem_ready) begin
          br_flag_d = branch_taken;
          state_d   = StWb;
        end else if (timeout) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end
      end
      StWb: begin
        retired_d = retired_q + 16'd1;
        if (halt_req)  state_d = StHalt;
        else if (run)  state_d = StFetch;
        else           state_d = StIdle;
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    phase   = 4'b0000;
    mem_req = 1'b0;
    ir_load = 1'b0;
    rf_we   = 1'b0;
    pc_n_pe = 1'b1;
    pc_cep  = 1'b0;
    pc_cet  = 1'b0;
    unique case (state_q)
      StFetch: begin
        phase   = 4'b0001;
        mem_req = 1'b1;
        ir_load = mem_ready;
      end
      StDecode: phase = 4'b0010;
      StExec: begin
        phase   = 4'b0100;
        mem_req = mem_flag_q;
      end
      StWb: begin
        phase   = 4'b1000;
        rf_we   = 1'b1;
        // Branch loads the target; otherwise the chain counts one word.
        pc_n_pe = !br_flag_q;
        pc_cep  = !br_flag_q;
        pc_cet  = !br_flag_q;
      end
      default: ;
    endcase
  end

  assign retired = retired_q;
  assign halted  = (state_q == StHalt);
  assign fault   = fault_q;

endmodule

// File: tb/tb_lmarv_cycle_sequencer.sv
// Scoreboard bench for lmarv_cycle_sequencer: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares. Timeout vectors run when SEQ_WAIT_TIMEOUT_EN is defined.
module tb_lmarv_cycle_sequencer;

  logic        cp = 1'b0;
  logic        n_mr, run, halt_req, mem_ready, need_mem, branch_taken;
  logic [3:0]  phase;
  logic        mem_req, ir_load, rf_we, pc_n_pe, pc_cep, pc_cet, halted, fault;
  logic [15:0] retired;

  lmarv_cycle_sequencer #(.WAIT_MAX(15)) dut (
    .cp(cp), .n_mr(n_mr), .run(run), .halt_req(halt_req), .mem_ready(mem_ready),
    .need_mem(need_mem), .branch_taken(branch_taken), .phase(phase), .mem_req(mem_req),
    .ir_load(ir_load), .rf_we(rf_we), .pc_n_pe(pc_n_pe), .pc_cep(pc_cep), .pc_cet(pc_cet),
    .retired(retired), .halted(halted), .fault(fault)
  );

  always #5 cp = ~cp;

  // Control word: {phase, mem_req, ir_load, rf_we, pc_n_pe, pc_cep, pc_cet, halted, fault}
  localparam logic [11:0] IDLE   = 12'b0000_0001_0000;
  localparam logic [11:0] F_W    = 12'b0001_1001_0000;
  localparam logic [11:0] F_R    = 12'b0001_1101_0000;
  localparam logic [11:0] DEC    = 12'b0010_0001_0000;
  localparam logic [11:0] EX     = 12'b0100_0001_0000;
  localparam logic [11:0] EXM    = 12'b0100_1001_0000;
  localparam logic [11:0] WB_N   = 12'b1000_0011_1100;
  localparam logic [11:0] WB_B   = 12'b1000_0010_0000;
  localparam logic [11:0] HALT   = 12'b0000_0001_0010;
  localparam logic [11:0] HALT_F = 12'b0000_0001_0011;

  typedef struct {
    logic [27:0] exp;
    string       name;
  } item_t;

  item_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  always @(negedge cp) begin
    if (sb_q.size() > 0) begin
      item_t it;
      logic [27:0] act;
      it  = sb_q.pop_front();
      act = {phase, mem_req, ir_load, rf_we, pc_n_pe, pc_cep, pc_cet, halted, fault, retired};
      n_vec++;
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s (vector %0d): got ctl=%b retired=%h, expected ctl=%b retired=%h",
                 it.name, n_vec, act[27:16], act[15:0], it.exp[27:16], it.exp[15:0]);
      end
    end
  end

  task automatic cyc(input logic nmr, input logic r, input logic h, input logic mr,
                     input logic nm, input logic bt, input logic [11:0] ctl,
                     input logic [15:0] ret, input string name);
    item_t it;
    @(posedge cp);
    #1;
    n_mr = nmr; run = r; halt_req = h; mem_ready = mr; need_mem = nm; branch_taken = bt;
    it.exp  = {ctl, ret};
    it.name = name;
    sb_q.push_back(it);
  endtask

  task automatic plain_instr(input logic [15:0] ret);
    cyc(1, 1, 0, 1, 0, 0, F_R,  ret, "fetch");
    cyc(1, 1, 0, 1, 0, 0, DEC,  ret, "decode");
    cyc(1, 1, 0, 1, 0, 0, EX,   ret, "exec");
    cyc(1, 1, 0, 1, 0, 0, WB_N, ret, "wb_count");
  endtask

  initial begin
    n_mr = 0; run = 0; halt_req = 0; mem_ready = 0; need_mem = 0; branch_taken = 0;
    cyc(0, 0, 0, 0, 0, 0, IDLE, 0, "reset");
    cyc(0, 1, 0, 1, 0, 0, IDLE, 0, "reset_held");
    cyc(1, 1, 0, 1, 0, 0, IDLE, 0, "idle_run");
    for (int k = 0; k < 3; k++) plain_instr(16'(k));
    // Taken branch, then a plain instruction that returns to counting.
    cyc(1, 1, 0, 1, 0, 0, F_R,  3, "br_fetch");
    cyc(1, 1, 0, 1, 0, 0, DEC,  3, "br_decode");
    cyc(1, 1, 0, 1, 0, 1, EX,   3, "br_exec");
    cyc(1, 1, 0, 1, 0, 0, WB_B, 3, "wb_branch_load");
    cyc(1, 1, 0, 1, 0, 0, F_R,  4, "post_br_fetch");
    cyc(1, 1, 0, 1, 0, 0, DEC,  4, "post_br_decode");
    cyc(1, 1, 0, 1, 0, 0, EX,   4, "post_br_exec");
    cyc(1, 0, 0, 1, 0, 0, WB_N, 4, "wb_after_branch");
    cyc(1, 0, 0, 1, 0, 0, IDLE, 5, "idle_no_run");
    cyc(1, 1, 0, 1, 0, 0, IDLE, 5, "idle_run2");
    // Memory EXEC with three wait cycles: 7-cycle instruction.
    cyc(1, 1, 0, 1, 0, 0, F_R,  5, "mem_fetch");
    cyc(1, 1, 0, 1, 1, 0, DEC,  5, "mem_decode");
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0, 0, EXM, 5, "mem_exec_wait");
    cyc(1, 1, 0, 1, 0, 0, EXM,  5, "mem_exec_ready");
    cyc(1, 1, 0, 1, 0, 0, WB_N, 5, "mem_wb");
    // Reset in the middle of a FETCH wait.
    cyc(1, 1, 0, 0, 0, 0, F_W,  6, "fetch_wait");
    cyc(1, 1, 0, 0, 0, 0, F_W,  6, "fetch_wait");
    cyc(0, 1, 0, 0, 0, 0, IDLE, 0, "reset_mid_wait");
    cyc(1, 1, 0, 1, 0, 0, IDLE, 0, "release_run");
    // Halt has priority over run in WB; HALT is absorbing.
    cyc(1, 1, 0, 1, 0, 0, F_R,  0, "fetch_after_reset");
    cyc(1, 1, 0, 1, 0, 0, DEC,  0, "decode");
    cyc(1, 1, 0, 1, 0, 0, EX,   0, "exec");
    cyc(1, 1, 1, 1, 0, 0, WB_N, 0, "wb_halt_req");
    for (int k = 0; k < 20; k++) cyc(1, 1, 0, 1, 0, 0, HALT, 1, "halt_absorbing");
    cyc(0, 1, 0, 1, 0, 0, IDLE, 0, "reset_from_halt");
    cyc(1, 0, 0, 1, 0, 0, IDLE, 0, "idle_after_halt");
    cyc(1, 0, 0, 1, 0, 0, IDLE, 0, "idle_after_halt");
`ifdef SEQ_WAIT_TIMEOUT_EN
    cyc(1, 1, 0, 0, 0, 0, IDLE, 0, "to_idle_run");
    for (int k = 0; k < 15; k++) cyc(1, 1, 0, 0, 0, 0, F_W, 0, "to_fetch_wait");
    cyc(1, 1, 0, 0, 0, 0, HALT_F, 0, "timeout_halt");
    cyc(1, 1, 0, 1, 0, 0, HALT_F, 0, "timeout_sticky");
    cyc(0, 1, 0, 0, 0, 0, IDLE, 0, "reset_clears_fault");
    cyc(1, 1, 0, 0, 0, 0, IDLE, 0, "to2_idle_run");
    for (int k = 0; k < 14; k++) cyc(1, 1, 0, 0, 0, 0, F_W, 0, "to2_fetch_wait");
    cyc(1, 1, 0, 1, 0, 0, F_R,  0, "ready_on_limit");
    cyc(1, 1, 0, 1, 0, 0, DEC,  0, "decode_no_fault");
    cyc(1, 1, 0, 1, 0, 0, EX,   0, "exec_no_fault");
    cyc(1, 1, 0, 1, 0, 0, WB_N, 0, "wb_no_fault");
    cyc(1, 1, 0, 1, 0, 0, F_R,  1, "fetch_after_limit");
`endif
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge cp);
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending vectors, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
